seq_pattern_gen: RTL and testbench

//  Serial pattern transmitter, the generating end of the serial sequence-detector link.
//  On start, emits a fixed PAT_W-bit pattern (default 1101) MSB first, one bit per clk.

---
 rtl/seq_pattern_pkg.sv | 18 +
 rtl/seq_pattern_shifter.sv | 50 +++++
 rtl/seq_pattern_gen.sv | 179 +++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pattern_pkg.sv
// Shared types and defaults for the serial pattern generator.
package seq_pattern_pkg;

    // Generator FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Default configuration
    localparam int         DEF_PAT_W   = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1101;
    localparam int         DEF_REP_W   = 8;
    localparam int         DEF_GAP_W   = 4;

endpackage

// File: rtl/seq_pattern_shifter.sv
// Loadable MSB-first shift register with a bit counter.
// Shifting fills with zeros, so once a full pattern has been shifted out
// the register reads all-zero and msb doubles as an idle-low serial output.
module seq_pattern_shifter #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [PAT_W-1:0] load_val,
    input  logic             shift,
    output logic             msb,
    output logic             last_bit
);

    localparam int CNT_W = $clog2(PAT_W);

    logic [PAT_W-1:0] shreg_reg;
    logic [PAT_W-1:0] shreg_shifted;
    logic [CNT_W-1:0] cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < PAT_W; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign shreg_shifted[gi] = 1'b0;
            end else begin : g_upper
                assign shreg_shifted[gi] = shreg_reg[gi-1];
            end
        end
    endgenerate

    assign msb      = shreg_reg[PAT_W-1];
    assign last_bit = (cnt_reg == CNT_W'(PAT_W - 1));

    // Load wins over shift; the counter wraps to 0 after the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_reg <= '0;
            cnt_reg   <= '0;
        end else if (load) begin
            shreg_reg <= load_val;
            cnt_reg   <= '0;
        end else if (shift) begin
            shreg_reg <= shreg_shifted;
            cnt_reg   <= last_bit ? '0 : cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends PATTERN MSB first, rep_cnt times with
// gap zero bits between repetitions, then pulses done.
// Optional SEQ_PATTERN_GEN_PROG_EN: adds pat_in, latched with start, which
// replaces PATTERN for that burst.
module seq_pattern_gen
    import seq_pattern_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
    parameter int               REP_W   = DEF_REP_W,
    parameter int               GAP_W   = DEF_GAP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [REP_W-1:0] rep_cnt,
    input  logic [GAP_W-1:0] gap,
`ifdef SEQ_PATTERN_GEN_PROG_EN
    input  logic [PAT_W-1:0] pat_in,
`endif
    output logic             seq,
    output logic             seq_valid,
    output logic             busy,
    output logic             done
);

    state_t           state_reg, state_next;
    logic [REP_W-1:0] rep_reg, rep_next;
    logic             cont_reg, cont_next;
    logic [GAP_W-1:0] gap_len_reg, gap_len_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic             stop_reg, stop_next;
    logic             valid_reg, valid_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic             sh_load;
    logic             sh_shift;
    logic [PAT_W-1:0] sh_load_val;
    logic             sh_last;
    logic [PAT_W-1:0] start_pat;
    logic [PAT_W-1:0] reload_pat;
    logic             stop_seen;

`ifdef SEQ_PATTERN_GEN_PROG_EN
    logic [PAT_W-1:0] pat_reg;

    // Hold the burst's programmed pattern for reloads between repetitions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_reg <= '0;
        end else if (state_reg == ST_IDLE && start) begin
            pat_reg <= pat_in;
        end
    end

    assign start_pat  = pat_in;
    assign reload_pat = pat_reg;
`else
    assign start_pat  = PATTERN;
    assign reload_pat = PATTERN;
`endif

    // stop raised this cycle counts as already seen
    assign stop_seen = stop_reg | stop;

    seq_pattern_shifter #(
        .PAT_W(PAT_W)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (sh_load),
        .load_val(sh_load_val),
        .shift   (sh_shift),
        .msb     (seq),
        .last_bit(sh_last)
    );

    // Next-state, counter and shifter control; outputs derived from the next state
    always_comb begin
        state_next   = state_reg;
        rep_next     = rep_reg;
        cont_next    = cont_reg;
        gap_len_next = gap_len_reg;
        gap_cnt_next = gap_cnt_reg;
        stop_next    = stop_reg;
        sh_load      = 1'b0;
        sh_shift     = 1'b0;
        sh_load_val  = reload_pat;

        case (state_reg)
            ST_IDLE: begin
                stop_next = 1'b0;
                if (start) begin
                    state_next   = ST_SEND;
                    rep_next     = rep_cnt;
                    cont_next    = (rep_cnt == '0);
                    gap_len_next = gap;
                    stop_next    = stop;
                    sh_load      = 1'b1;
                    sh_load_val  = start_pat;
                end
            end
            ST_SEND: begin
                stop_next = stop_seen;
                if (sh_last) begin
                    if (!cont_reg) begin
                        rep_next = rep_reg - REP_W'(1);
                    end
                    if ((!cont_reg && rep_reg == REP_W'(1)) || stop_seen) begin
                        state_next = ST_DONE;
                        sh_shift   = 1'b1;
                    end else if (gap_len_reg != '0) begin
                        state_next   = ST_GAP;
                        gap_cnt_next = '0;
                        sh_shift     = 1'b1;
                    end else begin
                        sh_load = 1'b1;
                    end
                end else begin
                    sh_shift = 1'b1;
                end
            end
            ST_GAP: begin
                stop_next = stop_seen;
                if (stop_seen) begin
                    state_next = ST_DONE;
                end else if (gap_cnt_reg == gap_len_reg - GAP_W'(1)) begin
                    state_next = ST_SEND;
                    sh_load    = 1'b1;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                stop_next  = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        valid_next = (state_next == ST_SEND) || (state_next == ST_GAP);
        busy_next  = valid_next;
        done_next  = (state_next == ST_DONE);
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            rep_reg     <= '0;
            cont_reg    <= 1'b0;
            gap_len_reg <= '0;
            gap_cnt_reg <= '0;
            stop_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rep_reg     <= rep_next;
            cont_reg    <= cont_next;
            gap_len_reg <= gap_len_next;
            gap_cnt_reg <= gap_cnt_next;
            stop_reg    <= stop_next;
            valid_reg   <= valid_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign seq_valid = valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: a burst model pushes the expected
// serial bits and done cycle; observed valid bits are popped and compared.
module tb_seq_pattern_gen;

    localparam int         PAT_W      = 4;
    localparam logic [3:0] TB_PATTERN = 4'b1101;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [7:0] rep_cnt;
    logic [3:0] gap;
`ifdef SEQ_PATTERN_GEN_PROG_EN
    logic [3:0] pat_in;
`endif
    logic       seq;
    logic       seq_valid;
    logic       busy;
    logic       done;

    int total_cnt = 0;
    int bad_cnt   = 0;

    seq_pattern_gen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .rep_cnt  (rep_cnt),
        .gap      (gap),
`ifdef SEQ_PATTERN_GEN_PROG_EN
        .pat_in   (pat_in),
`endif
        .seq      (seq),
        .seq_valid(seq_valid),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        total_cnt++;
        if (got != exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Runs one burst starting at cycle 0; caller is 1 time unit after a posedge.
    task automatic run_burst(input string name, input int rep, input int gp,
                             input int stop_cyc, input int restart_cyc,
                             input int exp_ticks);
        bit         exp_q[$];
        bit         eb;
        logic [3:0] pat_bits;
        logic [3:0] win;
        int         exp_done;
        int         t;
        int         ticks;
        int         nbits;
        int         done_at;
        bit         done_hit;

        // Burst model
        pat_bits = TB_PATTERN;
        t        = 1;
        exp_done = -1;
        for (int k = 0; k < 64 && exp_done < 0; k++) begin
            for (int b = PAT_W - 1; b >= 0; b--) begin
                exp_q.push_back(pat_bits[b]);
                t++;
            end
            if ((rep != 0 && k + 1 == rep) || (stop_cyc >= 0 && stop_cyc <= t - 1)) begin
                exp_done = t;
            end else begin
                for (int g = 0; g < gp && exp_done < 0; g++) begin
                    exp_q.push_back(1'b0);
                    if (stop_cyc == t) exp_done = t + 1;
                    t++;
                end
            end
        end

        win      = '0;
        ticks    = 0;
        nbits    = 0;
        done_at  = -1;
        done_hit = 1'b0;
        for (int c = 0; c < 300 && !done_hit; c++) begin
            start   = (c == 0) || (c == restart_cyc);
            stop    = (c == stop_cyc);
            rep_cnt = (c == 0) ? 8'(rep) : 8'hA5;
            gap     = (c == 0) ? 4'(gp)  : 4'hF;
            @(negedge clk);
            if (c == 0) begin
                check_eq({name, ":idle_valid"}, int'(seq_valid), 0);
            end else begin
                if (c == 1) begin
                    check_eq({name, ":first_valid"}, int'(seq_valid), 1);
                    check_eq({name, ":first_busy"}, int'(busy), 1);
                end
                if (seq_valid) begin
                    nbits++;
                    if (exp_q.size() == 0) begin
                        check_eq({name, ":extra_bit"}, 1, 0);
                    end else begin
                        eb = exp_q.pop_front();
                        check_eq({name, ":bit"}, int'(seq), int'(eb));
                    end
                    win = {win[2:0], seq};
                    if (win == 4'b1101) ticks++;
                end
                if (done) begin
                    done_hit = 1'b1;
                    done_at  = c;
                    check_eq({name, ":done_cycle"}, c, exp_done);
                    check_eq({name, ":done_busy"}, int'(busy), 0);
                    check_eq({name, ":done_valid"}, int'(seq_valid), 0);
                    check_eq({name, ":bits_left"}, exp_q.size(), 0);
                    if (exp_ticks >= 0) check_eq({name, ":det_ticks"}, ticks, exp_ticks);
                end
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        stop  = 1'b0;
        if (!done_hit) begin
            check_eq({name, ":timeout"}, 0, 1);
        end else begin
            @(negedge clk);
            check_eq({name, ":done_pulse"}, int'(done), 0);
            @(posedge clk);
            #1;
        end
        $display("burst %s: rep=%0d gap=%0d bits=%0d ticks=%0d done_at=%0d",
                 name, rep, gp, nbits, ticks, done_at);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        rep_cnt = '0;
        gap     = '0;
`ifdef SEQ_PATTERN_GEN_PROG_EN
        pat_in  = 4'b1101;
`endif
        #2;
        check_eq("rst_seq", int'(seq), 0);
        check_eq("rst_valid", int'(seq_valid), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_burst("single",       1, 0, -1, -1, 1);
        run_burst("triple",       3, 0, -1, -1, 3);
        run_burst("gap2",         2, 2, -1, -1, 2);
        run_burst("continuous",   0, 0,  6, -1, 2);
        run_burst("restart",      1, 0, -1,  2, 1);
        run_burst("start_stop",   5, 3,  0, -1, 1);
        run_burst("stop_in_gap",  2, 3,  6, -1, 1);

        // Reset in the middle of a burst
        start   = 1'b1;
        rep_cnt = 8'd1;
        gap     = 4'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_eq("pre_rst_valid", int'(seq_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_seq", int'(seq), 0);
        check_eq("async_rst_valid", int'(seq_valid), 0);
        check_eq("async_rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_done", int'(done), 0);
        check_eq("post_rst_valid", int'(seq_valid), 0);
        @(posedge clk);
        #1;
        run_burst("after_rst", 1, 0, -1, -1, 1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
